// File: rtl/uart_pixel_loader_pkg.sv
// Shared frame geometry and state encoding for the UART loader, Sobel window and VGA read side.
package uart_pixel_loader_pkg;

  localparam int IMG_W       = 200;
  localparam int IMG_H       = 200;
  localparam int FRAME_PIX   = IMG_W * IMG_H;
  localparam int ADDR_W      = 16;
  localparam int TIMEOUT_CYC = 20000;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_pixel_loader_idle_timer.sv
// Counts sclk cycles without a received byte while a frame is loading; pulses at the terminal count.
module loader_idle_timer #(
  parameter int TIMEOUT_CYC = uart_pixel_loader_pkg::TIMEOUT_CYC
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic terminal
);
  import uart_pixel_loader_pkg::*;

  localparam int CNT_W = width_for(TIMEOUT_CYC);

  logic [CNT_W-1:0] idle_cnt;

  // A byte arriving on the terminal cycle suppresses the pulse.
  assign terminal = enable && !clear && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sclk) begin
    if (!rst_n || clear || !enable || terminal) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_pixel_loader.sv
// Turns the UART byte stream into raster-ordered frame-RAM writes with completion and stall recovery.
module uart_pixel_loader #(
  parameter int IMG_W       = uart_pixel_loader_pkg::IMG_W,
  parameter int IMG_H       = uart_pixel_loader_pkg::IMG_H,
  parameter int ADDR_W      = uart_pixel_loader_pkg::ADDR_W,
  parameter int TIMEOUT_CYC = uart_pixel_loader_pkg::TIMEOUT_CYC
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [7:0]        po_data,
  input  logic              po_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              busy,
  output logic              err_timeout
);
  import uart_pixel_loader_pkg::*;

  localparam int X_W = width_for(IMG_W);
  localparam int Y_W = width_for(IMG_H);

  state_t            state;
  state_t            state_next;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              x_last;
  logic              last_pix;
  logic              timeout;

  assign x_last   = (x == X_W'(IMG_W - 1));
  assign last_pix = x_last && (y == Y_W'(IMG_H - 1));
  assign busy     = (state == LOAD);

  loader_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .enable  (state == LOAD),
    .clear   (po_flag),
    .terminal(timeout)
  );

  // In IDLE x=y=0, so last_pix there only holds for a one-pixel frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (po_flag && !last_pix) state_next = LOAD;
      LOAD: begin
        if (po_flag && last_pix) state_next = IDLE;
        else if (timeout)        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wr_en       <= po_flag;
      frame_done  <= po_flag && last_pix;
      err_timeout <= timeout;
      if (po_flag) begin
        wr_addr     <= addr;
        wr_data     <= po_data;
        frame_valid <= last_pix;
        if (last_pix) begin
          x    <= '0;
          y    <= '0;
          addr <= '0;
        end else if (x_last) begin
          x    <= '0;
          y    <= y + Y_W'(1);
          addr <= addr + ADDR_W'(1);
        end else begin
          x    <= x + X_W'(1);
          addr <= addr + ADDR_W'(1);
        end
      end else if (timeout) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end
    end
  end

endmodule
